// File: rtl/mshr_miss_queue.sv
// mshr_miss_queue
// Miss-status holding queue between the data-cache access pipeline and the
// memory bus. Each distinct missing line gets one entry. A secondary miss to a
// line that is already pending is merged into that entry. Each entry can issue
// a dirty-victim writeback, then always issues a line read. Read beats are
// assembled into a line and handed back to the cache as in-order refills.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   req_*                miss request from the cache (valid/ready handshake)
//   req_merged           accepted request hit a pending line, so no allocation
//   mem_*                command channel to memory (line write or line read)
//   mem_rvalid/rdata/... read-beat return channel, one 32-bit word per beat
//   refill_*             assembled line handed to the cache (valid/ready)
//   busy                 an entry is valid or a refill is pending
//
// Issue FSM
//   state | meaning
//   IDLE  | no command presented; waits for an unissued entry at issue_ptr
//   WB    | presenting the victim writeback of entry[issue_ptr]
//   RD    | presenting the line read of entry[issue_ptr]
module mshr_miss_queue #(
  parameter int DEPTH      = 8,
  parameter int LINE_WORDS = 4,
  localparam int OFF_W = $clog2(LINE_WORDS * 4),
  localparam int LA_W  = 32 - OFF_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic                     req_dirty,
  input  logic [LA_W-1:0]          req_victim_la,
  input  logic [LINE_WORDS*32-1:0] req_victim_data,
  output logic                     req_merged,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic                     mem_wen,
  output logic [31:0]              mem_addr,
  output logic [LINE_WORDS*32-1:0] mem_wdata,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  output logic                     mem_rready,
  output logic                     refill_valid,
  input  logic                     refill_ready,
  output logic [LA_W-1:0]          refill_la,
  output logic [LINE_WORDS*32-1:0] refill_data,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int LW = LINE_WORDS * 32;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_RD} state_t;

  state_t state;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_wb;
  logic [DEPTH-1:0] ent_issued;
  logic [LA_W-1:0]  ent_la          [DEPTH];
  logic [LA_W-1:0]  ent_victim_la   [DEPTH];
  logic [LW-1:0]    ent_victim_data [DEPTH];

  logic [PW-1:0] alloc_ptr, issue_ptr, done_ptr, resp_ptr;
  logic [CW-1:0] count;
  logic [BW-1:0] beat_cnt;

  logic [LA_W-1:0] req_la;
  logic match, accept, alloc_now;
  logic wb_fire, rd_fire, beat_fire, last_beat, retire;
  logic unused_addr_bits;

  assign req_la           = req_addr[31:OFF_W];
  assign unused_addr_bits = ^req_addr[OFF_W-1:0];

  // The line being handed back still counts as pending until the cache takes it.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_la[i] == req_la) match = 1'b1;
    end
    if (refill_valid && refill_la == req_la) match = 1'b1;
  end

  assign req_ready  = resetn & (match | (count != CW'(DEPTH)));
  assign req_merged = resetn & req_valid & match;
  assign accept     = req_valid & req_ready;
  assign alloc_now  = accept & ~match;

  assign wb_fire    = (state == S_WB) & mem_ready;
  assign rd_fire    = (state == S_RD) & mem_ready;
  assign mem_addr   = {(mem_wen ? ent_victim_la[issue_ptr] : ent_la[issue_ptr]), {OFF_W{1'b0}}};
  assign mem_wdata  = ent_victim_data[issue_ptr];

  assign mem_rready = resetn & (~refill_valid | refill_ready);
  assign beat_fire  = mem_rvalid & mem_rready;
  assign last_beat  = beat_fire & (beat_cnt == BW'(LINE_WORDS - 1));
  assign retire     = refill_valid & refill_ready;
  assign busy       = (count != '0) | refill_valid;

  // While a refill is held, the line being assembled is the one after it.
  assign resp_ptr = refill_valid ? done_ptr + 1'b1 : done_ptr;

  // Issue FSM. The IDLE bypass lets a miss allocated into an empty queue
  // present its command on the cycle right after acceptance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      issue_ptr <= '0;
      mem_valid <= 1'b0;
      mem_wen   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ent_valid[issue_ptr] && !ent_issued[issue_ptr]) begin
            state     <= ent_wb[issue_ptr] ? S_WB : S_RD;
            mem_valid <= 1'b1;
            mem_wen   <= ent_wb[issue_ptr];
          end else if (alloc_now && alloc_ptr == issue_ptr) begin
            state     <= req_dirty ? S_WB : S_RD;
            mem_valid <= 1'b1;
            mem_wen   <= req_dirty;
          end
        end
        S_WB: begin
          if (mem_ready) begin
            state   <= S_RD;
            mem_wen <= 1'b0;
          end
        end
        S_RD: begin
          if (mem_ready) begin
            state     <= S_IDLE;
            mem_valid <= 1'b0;
            issue_ptr <= issue_ptr + 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          mem_valid <= 1'b0;
          mem_wen   <= 1'b0;
        end
      endcase
    end
  end

  // Entry status bits. The allocation target is always a free slot, so it
  // never collides with the slot retiring in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ent_valid  <= '0;
      ent_wb     <= '0;
      ent_issued <= '0;
      alloc_ptr  <= '0;
    end else begin
      if (alloc_now) begin
        ent_valid[alloc_ptr]  <= 1'b1;
        ent_wb[alloc_ptr]     <= req_dirty;
        ent_issued[alloc_ptr] <= 1'b0;
        alloc_ptr             <= alloc_ptr + 1'b1;
      end
      if (wb_fire) ent_wb[issue_ptr] <= 1'b0;
      if (rd_fire) ent_issued[issue_ptr] <= 1'b1;
      if (retire)  ent_valid[done_ptr] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_now) begin
      ent_la[alloc_ptr]          <= req_la;
      ent_victim_la[alloc_ptr]   <= req_victim_la;
      ent_victim_data[alloc_ptr] <= req_victim_data;
    end
  end

  // Refill assembly. Beats land directly in refill_data: no beat is accepted
  // while a held line is still visible to the cache.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt     <= '0;
      refill_valid <= 1'b0;
      refill_la    <= '0;
      refill_data  <= '0;
      done_ptr     <= '0;
      count        <= '0;
    end else begin
      if (beat_fire) begin
        refill_data[32*beat_cnt +: 32] <= mem_rdata;
        beat_cnt                       <= beat_cnt + 1'b1;
      end
      if (last_beat) begin
        refill_valid <= 1'b1;
        refill_la    <= ent_la[resp_ptr];
      end else if (retire) begin
        refill_valid <= 1'b0;
      end
      if (retire) done_ptr <= done_ptr + 1'b1;
      case ({alloc_now, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mshr_miss_queue.sv
module tb_mshr_miss_queue;

  localparam int DEPTH = 8;
  localparam int LINE_WORDS = 4;
  localparam int LA_W = 28;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [31:0]         req_addr = '0;
  logic                req_dirty = 1'b0;
  logic [LA_W-1:0]     req_victim_la = '0;
  logic [127:0]        req_victim_data = '0;
  logic                req_merged;
  logic                mem_valid;
  logic                mem_ready = 1'b0;
  logic                mem_wen;
  logic [31:0]         mem_addr;
  logic [127:0]        mem_wdata;
  logic                mem_rvalid = 1'b0;
  logic [31:0]         mem_rdata = '0;
  logic                mem_rready;
  logic                refill_valid;
  logic                refill_ready = 1'b0;
  logic [LA_W-1:0]     refill_la;
  logic [127:0]        refill_data;
  logic                busy;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [127:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [LA_W-1:0] la;
    logic [127:0]    data;
  } rf_t;

  cmd_t exp_cmd[$];
  rf_t  exp_rf[$];
  int   n_checks = 0;
  int   n_fail = 0;

  mshr_miss_queue #(.DEPTH(DEPTH), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_dirty(req_dirty), .req_victim_la(req_victim_la),
    .req_victim_data(req_victim_data), .req_merged(req_merged),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
    .refill_valid(refill_valid), .refill_ready(refill_ready),
    .refill_la(refill_la), .refill_data(refill_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, test did not complete");
    $fatal(1, "watchdog");
  end

  // Inputs change on the falling edge; outputs are observed 1 time unit later.
  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0; req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; refill_ready = 1'b0;
    #1;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    exp_cmd.delete();
    exp_rf.delete();
  endtask

  task automatic do_req(input logic [31:0] addr, input logic dirty, input logic [LA_W-1:0] vla,
                        input logic [127:0] vdata, input logic exp_alloc,
                        output logic rdy, output logic mrg);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_dirty = dirty;
    req_victim_la = vla; req_victim_data = vdata;
    #1;
    rdy = req_ready;
    mrg = req_merged;
    if (exp_alloc) begin
      if (dirty) exp_cmd.push_back(cmd_t'({1'b1, vla, 4'h0, vdata}));
      exp_cmd.push_back(cmd_t'({1'b0, addr[31:4], 4'h0, 128'h0}));
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
  endtask

  task automatic get_cmd(input int stall, output logic ok, output cmd_t c, output logic stable);
    int n = 0;
    ok = 1'b1;
    stable = 1'b1;
    c = '0;
    while (!mem_valid && n < 100) begin @(negedge clk); #1; n++; end
    if (!mem_valid) begin ok = 1'b0; return; end
    c = {mem_wen, mem_addr, mem_wdata};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); #1;
      if (!mem_valid || {mem_wen, mem_addr, mem_wdata} !== c) stable = 1'b0;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
  endtask

  task automatic send_beats(input logic [3:0][31:0] w, input int first, input int last, output logic ok);
    int n;
    ok = 1'b1;
    for (int k = first; k <= last; k++) begin
      n = 0;
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = w[k];
      #1;
      while (!mem_rready && n < 100) begin @(negedge clk); #1; n++; end
      if (!mem_rready) ok = 1'b0;
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
  endtask

  task automatic take_refill(output logic ok, output rf_t r);
    int n = 0;
    ok = 1'b1;
    r = '0;
    while (!refill_valid && n < 100) begin @(negedge clk); #1; n++; end
    if (!refill_valid) begin ok = 1'b0; return; end
    r = {refill_la, refill_data};
    refill_ready = 1'b1;
    @(negedge clk);
    refill_ready = 1'b0;
    #1;
  endtask

  function automatic logic [3:0][31:0] rand_line();
    logic [3:0][31:0] w;
    for (int k = 0; k < 4; k++) w[k] = $urandom;
    return w;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    req_valid = 1'b1;
    req_addr = 32'h0000_1234;
    @(negedge clk); #1;
    n_checks++;
    if ({req_ready, req_merged, mem_valid, mem_rready, refill_valid, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected 000000", {req_ready, req_merged, mem_valid, mem_rready, refill_valid, busy});
    end
    @(negedge clk);
    req_valid = 1'b0;
    resetn = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, busy, mem_valid, refill_valid, mem_rready} !== 5'b10001) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b, expected 10001", {req_ready, busy, mem_valid, refill_valid, mem_rready});
    end
  endtask

  task automatic test_clean_miss();
    logic rdy, mrg, ok, st;
    cmd_t c, e;
    rf_t r, er;
    logic [3:0][31:0] w;
    do_req(32'h0000_1234, 1'b0, '0, '0, 1'b1, rdy, mrg);
    n_checks++;
    if ({rdy, mrg} !== 2'b10) begin n_fail++; $display("FAIL clean_accept: got %b, expected 10", {rdy, mrg}); end
    n_checks++;
    if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL clean_latency: mem_valid %b, expected 1", mem_valid); end
    get_cmd(0, ok, c, st);
    e = exp_cmd.pop_front();
    n_checks++;
    if (!ok || {c.wen, c.addr} !== {e.wen, e.addr}) begin
      n_fail++; $display("FAIL clean_cmd: ok %b wen %b addr %h, expected wen %b addr %h", ok, c.wen, c.addr, e.wen, e.addr);
    end
    w = {32'd4, 32'd3, 32'd2, 32'd1};
    exp_rf.push_back(rf_t'({28'h000_0123, w}));
    send_beats(w, 0, 3, ok);
    n_checks++;
    if (!ok || refill_valid !== 1'b1) begin
      n_fail++; $display("FAIL clean_refill_latency: beats_ok %b refill_valid %b, expected 1 1", ok, refill_valid);
    end
    take_refill(ok, r);
    er = exp_rf.pop_front();
    n_checks++;
    if (!ok || r !== er) begin
      n_fail++; $display("FAIL clean_refill: la %h data %h, expected la %h data %h", r.la, r.data, er.la, er.data);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL clean_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_dirty_merge();
    logic rdy, mrg, ok, st, extra;
    cmd_t c, e;
    rf_t r, er;
    logic [3:0][31:0] w, v;
    v = rand_line();
    do_req(32'h0000_2000, 1'b1, 28'h000_00AB, v, 1'b1, rdy, mrg);
    n_checks++;
    if ({rdy, mrg} !== 2'b10) begin n_fail++; $display("FAIL dirty_accept: got %b, expected 10", {rdy, mrg}); end
    do_req(32'h0000_2008, 1'b0, '0, '0, 1'b0, rdy, mrg);
    n_checks++;
    if ({rdy, mrg} !== 2'b11) begin n_fail++; $display("FAIL merge_flags: got %b, expected 11", {rdy, mrg}); end
    get_cmd(3, ok, c, st);
    e = exp_cmd.pop_front();
    n_checks++;
    if (!ok || !st || c !== e) begin
      n_fail++; $display("FAIL wb_cmd: ok %b stable %b wen %b addr %h data %h, expected wen %b addr %h data %h",
                        ok, st, c.wen, c.addr, c.wdata, e.wen, e.addr, e.wdata);
    end
    get_cmd(0, ok, c, st);
    e = exp_cmd.pop_front();
    n_checks++;
    if (!ok || {c.wen, c.addr} !== {e.wen, e.addr}) begin
      n_fail++; $display("FAIL dirty_rd_cmd: ok %b wen %b addr %h, expected wen %b addr %h", ok, c.wen, c.addr, e.wen, e.addr);
    end
    extra = 1'b0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); #1; extra |= mem_valid; end
    n_checks++;
    if (extra !== 1'b0) begin n_fail++; $display("FAIL merge_single_read: extra command seen %b, expected 0", extra); end
    w = rand_line();
    exp_rf.push_back(rf_t'({28'h000_0200, w}));
    send_beats(w, 0, 3, ok);
    take_refill(ok, r);
    er = exp_rf.pop_front();
    n_checks++;
    if (!ok || r !== er) begin
      n_fail++; $display("FAIL dirty_refill: la %h data %h, expected la %h data %h", r.la, r.data, er.la, er.data);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL merge_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_full();
    logic rdy, mrg, ok, st;
    int acc;
    cmd_t c, e;
    rf_t r, er;
    logic [3:0][31:0] w;
    apply_reset();
    acc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      do_req(32'h0001_0000 + 32'(i * 16), 1'b0, '0, '0, 1'b1, rdy, mrg);
      if (rdy && !mrg) acc++;
    end
    n_checks++;
    if (acc !== DEPTH) begin n_fail++; $display("FAIL fill_accepts: got %0d, expected %0d", acc, DEPTH); end
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0002_0000; req_dirty = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b, expected 0", req_ready); end
    get_cmd(0, ok, c, st);
    e = exp_cmd.pop_front();
    n_checks++;
    if (!ok || {c.wen, c.addr} !== {e.wen, e.addr}) begin
      n_fail++; $display("FAIL full_first_cmd: ok %b addr %h, expected addr %h", ok, c.addr, e.addr);
    end
    w = rand_line();
    exp_rf.push_back(rf_t'({e.addr[31:4], w}));
    send_beats(w, 0, 3, ok);
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_held: got %b, expected 0", req_ready); end
    take_refill(ok, r);
    er = exp_rf.pop_front();
    n_checks++;
    if (!ok || r !== er) begin
      n_fail++; $display("FAIL full_first_refill: la %h, expected la %h", r.la, er.la);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_retire_ready: got %b, expected 1", req_ready); end
    exp_cmd.push_back(cmd_t'({1'b0, 32'h0002_0000, 128'h0}));
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      get_cmd(0, ok, c, st);
      e = exp_cmd.pop_front();
      n_checks++;
      if (!ok || {c.wen, c.addr} !== {e.wen, e.addr}) begin
        n_fail++; $display("FAIL drain_cmd_%0d: ok %b addr %h, expected addr %h", i, ok, c.addr, e.addr);
      end
      w = rand_line();
      exp_rf.push_back(rf_t'({e.addr[31:4], w}));
      send_beats(w, 0, 3, ok);
      take_refill(ok, r);
      er = exp_rf.pop_front();
      n_checks++;
      if (!ok || r !== er) begin
        n_fail++; $display("FAIL drain_refill_%0d: la %h data %h, expected la %h data %h", i, r.la, r.data, er.la, er.data);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_backpressure();
    logic rdy, mrg, ok, st, stall_bad;
    cmd_t c, e;
    rf_t r, er;
    logic [3:0][31:0] wa, wb;
    apply_reset();
    do_req(32'h0000_3000, 1'b0, '0, '0, 1'b1, rdy, mrg);
    do_req(32'h0000_3010, 1'b0, '0, '0, 1'b1, rdy, mrg);
    for (int i = 0; i < 2; i++) begin
      get_cmd(0, ok, c, st);
      e = exp_cmd.pop_front();
      n_checks++;
      if (!ok || {c.wen, c.addr} !== {e.wen, e.addr}) begin
        n_fail++; $display("FAIL bp_cmd_%0d: ok %b addr %h, expected addr %h", i, ok, c.addr, e.addr);
      end
    end
    wa = rand_line();
    wb = rand_line();
    exp_rf.push_back(rf_t'({28'h000_0300, wa}));
    send_beats(wa, 0, 3, ok);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = wb[0];
    #1;
    stall_bad = mem_rready;
    for (int i = 0; i < 2; i++) begin @(negedge clk); #1; stall_bad |= mem_rready; end
    n_checks++;
    if (stall_bad !== 1'b0 || refill_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_rready_held: rready seen %b refill_valid %b, expected 0 1", stall_bad, refill_valid);
    end
    @(negedge clk);
    refill_ready = 1'b1;
    #1;
    n_checks++;
    if (mem_rready !== 1'b1) begin n_fail++; $display("FAIL bp_rready_release: got %b, expected 1", mem_rready); end
    r = {refill_la, refill_data};
    er = exp_rf.pop_front();
    n_checks++;
    if (r !== er) begin
      n_fail++; $display("FAIL bp_first_refill: la %h data %h, expected la %h data %h", r.la, r.data, er.la, er.data);
    end
    @(negedge clk);
    refill_ready = 1'b0; mem_rvalid = 1'b0;
    #1;
    exp_rf.push_back(rf_t'({28'h000_0301, wb}));
    send_beats(wb, 1, 3, ok);
    take_refill(ok, r);
    er = exp_rf.pop_front();
    n_checks++;
    if (!ok || r !== er) begin
      n_fail++; $display("FAIL bp_second_refill: la %h data %h, expected la %h data %h", r.la, r.data, er.la, er.data);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_reset_mid_burst();
    logic rdy, mrg, ok, st;
    cmd_t c, e;
    rf_t r, er;
    logic [3:0][31:0] w;
    apply_reset();
    do_req(32'h0000_4000, 1'b0, '0, '0, 1'b1, rdy, mrg);
    get_cmd(0, ok, c, st);
    e = exp_cmd.pop_front();
    w = rand_line();
    send_beats(w, 0, 1, ok);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = w[2];
    req_valid = 1'b1; req_addr = 32'h0000_4000;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, req_merged, mem_valid, mem_rready, refill_valid, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL midburst_reset_outputs: got %b, expected 000000", {req_ready, req_merged, mem_valid, mem_rready, refill_valid, busy});
    end
    mem_rvalid = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    exp_cmd.delete();
    exp_rf.delete();
    do_req(32'h0000_5000, 1'b0, '0, '0, 1'b1, rdy, mrg);
    n_checks++;
    if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_latency: mem_valid %b, expected 1", mem_valid); end
    get_cmd(0, ok, c, st);
    e = exp_cmd.pop_front();
    n_checks++;
    if (!ok || {c.wen, c.addr} !== {e.wen, e.addr}) begin
      n_fail++; $display("FAIL post_reset_cmd: ok %b addr %h, expected addr %h", ok, c.addr, e.addr);
    end
    w = rand_line();
    exp_rf.push_back(rf_t'({28'h000_0500, w}));
    send_beats(w, 0, 3, ok);
    take_refill(ok, r);
    er = exp_rf.pop_front();
    n_checks++;
    if (!ok || r !== er) begin
      n_fail++; $display("FAIL post_reset_refill: la %h data %h, expected la %h data %h", r.la, r.data, er.la, er.data);
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_merge();
    test_full();
    test_backpressure();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
